dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_pkg.sv | 33 +++
 rtl/dmem_access_ctrl_store_align.sv | 47 ++++
 rtl/dmem_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared constants for the data-memory access controller:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state encoding (ST_IDLE / ST_REQ / ST_RESP)
//   - word-aligned bus address mask
//   - is_misaligned(): alignment test used when MISALIGN_TRAP_EN is defined
// -----------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

  // Byte accesses can never be misaligned; size 2'b11 is checked as a word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lsb);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lsb[0];
      default: mis = (addr_lsb != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_store_align.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_store_align  (store_align)
// Combinational byte-lane alignment of store data and byte-write mask.
// Ports:
//   store_i     : 1 = store, 0 = load (loads get an all-zero mask)
//   size_i      : access size (byte / half / word, 2'b11 treated as word)
//   addr_lsb_i  : byte address bits [1:0]
//   wdata_i     : unaligned store data (rs2)
//   wdata_o     : data replicated into every lane it may land in
//   mask_o      : byte-write enables, bit n = byte lane n
// -----------------------------------------------------------------------------
module dmem_access_ctrl_store_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic        store_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  mask_o
);

  logic [3:0] mask_raw;

  always_comb begin
    wdata_o  = wdata_i;
    mask_raw = 4'b1111;
    case (size_i)
      SZ_BYTE: begin
        wdata_o  = {4{wdata_i[7:0]}};
        mask_raw = 4'b0001 << addr_lsb_i;
      end
      SZ_HALF: begin
        wdata_o  = {2{wdata_i[15:0]}};
        // addr[0] is ignored here: a misaligned half still lands in the
        // half selected by addr[1].
        mask_raw = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_o  = wdata_i;
        mask_raw = 4'b1111;
      end
    endcase
    mask_o = store_i ? mask_raw : 4'b0000;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Data-memory access controller between the execute stage and the dmem bus.
// One op at a time: IDLE accepts, REQ holds the bus request until ack or
// timeout, RESP is a single-cycle completion (done_out or err_out).
//
// Parameter:
//   TIMEOUT_CYCLES : cycles REQ may wait for dmem_ack_in (1..255)
// Optional build macro:
//   MISALIGN_TRAP_EN : misaligned half/word ops trap (err_out) without a bus
//                      request; when undefined they are issued as normal.
// Ports:
//   clk_in, rst_n_in            : clock, async active-low reset
//   req_valid_in/req_ready_out  : op handshake from execute (ready only in IDLE)
//   req_store_in, req_addr_in, req_size_in, req_wdata_in : op fields
//   dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out
//                               : bus request, held stable while in REQ
//   dmem_ack_in, dmem_rdata_in  : bus completion and read data
//   ld_data_out, ld_addr_lsb_out: last captured load word and its addr[1:0]
//   done_out, err_out           : one-cycle completion / error pulses
//   busy_out                    : high whenever not IDLE (pipeline stall)
// -----------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_store_in,
  input  logic [31:0] req_addr_in,
  input  logic [1:0]  req_size_in,
  input  logic [31:0] req_wdata_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_mask_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] ld_data_out,
  output logic [1:0]  ld_addr_lsb_out,
  output logic        done_out,
  output logic        err_out,
  output logic        busy_out
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [1:0]  ld_lsb_q, ld_lsb_d;

  logic [31:0] align_wdata;
  logic [3:0]  align_mask;

  dmem_access_ctrl_store_align u_store_align (
    .store_i    (req_store_in),
    .size_i     (req_size_in),
    .addr_lsb_i (req_addr_in[1:0]),
    .wdata_i    (req_wdata_in),
    .wdata_o    (align_wdata),
    .mask_o     (align_mask)
  );

  // The access size is folded into the latched wdata/mask at accept time,
  // so it does not need its own register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    store_d   = store_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
    ld_lsb_d  = ld_lsb_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          store_d = req_store_in;
          addr_d  = req_addr_in;
          wdata_d = align_wdata;
          mask_d  = align_mask;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end

      ST_REQ: begin
        // An ack in the same cycle the limit is reached still wins.
        if (dmem_ack_in) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (!store_q) begin
            ld_data_d = dmem_rdata_in;
            ld_lsb_d  = addr_q[1:0];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      store_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      mask_q    <= 4'd0;
      err_q     <= 1'b0;
      ld_data_q <= 32'd0;
      ld_lsb_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
      ld_lsb_q  <= ld_lsb_d;
    end
  end

  assign req_ready_out   = (state_q == ST_IDLE);
  assign busy_out        = (state_q != ST_IDLE);
  assign dmem_req_out    = (state_q == ST_REQ);
  // Write enable and mask only qualify an active request.
  assign dmem_we_out     = dmem_req_out & store_q;
  assign dmem_mask_out   = dmem_req_out ? mask_q : 4'b0000;
  assign dmem_addr_out   = addr_q & ADDR_WORD_MASK;
  assign dmem_wdata_out  = wdata_q;
  assign done_out        = (state_q == ST_RESP) & ~err_q;
  assign err_out         = (state_q == ST_RESP) &  err_q;
  assign ld_data_out     = ld_data_q;
  assign ld_addr_lsb_out = ld_lsb_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Self-checking bench for dmem_access_ctrl (TIMEOUT_CYCLES = 4). Directed ops
// followed by random ops, all checked against a lane-level reference model.
// Honours MISALIGN_TRAP_EN when the same macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam int TO = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ld_data;
  logic [1:0]  ld_lsb;
  logic        done;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ld_data = 32'd0;
  logic [1:0]  exp_ld_lsb  = 2'd0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req_valid_in    (req_valid),
    .req_ready_out   (req_ready),
    .req_store_in    (req_store),
    .req_addr_in     (req_addr),
    .req_size_in     (req_size),
    .req_wdata_in    (req_wdata),
    .dmem_req_out    (dmem_req),
    .dmem_we_out     (dmem_we),
    .dmem_addr_out   (dmem_addr),
    .dmem_wdata_out  (dmem_wdata),
    .dmem_mask_out   (dmem_mask),
    .dmem_ack_in     (dmem_ack),
    .dmem_rdata_in   (dmem_rdata),
    .ld_data_out     (ld_data),
    .ld_addr_lsb_out (ld_lsb),
    .done_out        (done),
    .err_out         (err),
    .busy_out        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {mask, wdata}: each byte lane picks the source byte that the
  // access size routes into it; the mask marks lanes the access covers.
  function automatic logic [35:0] model_align(input logic st, input logic [1:0] sz,
                                              input logic [1:0] lsb, input logic [31:0] w);
    logic [31:0] wd;
    logic [3:0]  m;
    for (int i = 0; i < 4; i++) begin
      case (sz)
        2'b00: begin
          wd[8*i +: 8] = w[7:0];
          m[i] = (i == int'(lsb));
        end
        2'b01: begin
          wd[8*i +: 8] = w[8*(i%2) +: 8];
          m[i] = ((i / 2) == int'(lsb[1]));
        end
        default: begin
          wd[8*i +: 8] = w[8*i +: 8];
          m[i] = 1'b1;
        end
      endcase
    end
    if (!st) m = 4'b0000;
    return {m, wd};
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [1:0] lsb);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return lsb[0];
    return lsb != 2'b00;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(dmem_req),   32'd0);
    chk({tag, "_we"},    32'(dmem_we),    32'd0);
    chk({tag, "_mask"},  32'(dmem_mask),  32'd0);
    chk({tag, "_addr"},  dmem_addr,       32'd0);
    chk({tag, "_wdata"}, dmem_wdata,      32'd0);
    chk({tag, "_ld"},    ld_data,         32'd0);
    chk({tag, "_lsb"},   32'(ld_lsb),     32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  // ack_dly: REQ cycle (1-based) in which ack is driven; 0 or > TO = no ack.
  task automatic do_op(input string tag, input logic st, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] w,
                       input int ack_dly, input logic [31:0] rd);
    logic [35:0] al;
    bit acked;
    al = model_align(st, sz, a[1:0], w);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_store = st;
    req_addr  = a;
    req_size  = sz;
    req_wdata = w;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    if (TRAP && model_mis(sz, a[1:0])) begin
      chk({tag, "_trap_req"},  32'(dmem_req), 32'd0);
      chk({tag, "_trap_err"},  32'(err),      32'd1);
      chk({tag, "_trap_done"}, 32'(done),     32'd0);
      chk({tag, "_trap_busy"}, 32'(busy),     32'd1);
    end else begin
      acked = 1'b0;
      for (int cyc = 1; cyc <= TO; cyc++) begin
        chk({tag, "_req"},  32'(dmem_req),  32'd1);
        chk({tag, "_busy"}, 32'(busy),      32'd1);
        chk({tag, "_rdy"},  32'(req_ready), 32'd0);
        chk({tag, "_done"}, 32'(done),      32'd0);
        chk({tag, "_addr"}, dmem_addr,      {a[31:2], 2'b00});
        chk({tag, "_we"},   32'(dmem_we),   32'(st));
        chk({tag, "_mask"}, 32'(dmem_mask), 32'(al[35:32]));
        if (st) chk({tag, "_wdata"}, dmem_wdata, al[31:0]);
        if (cyc == ack_dly) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rd;
          acked      = 1'b1;
        end else begin
          dmem_rdata = $urandom;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        if (acked) break;
      end
      // Now in the single completion cycle.
      chk({tag, "_resp_req"},  32'(dmem_req), 32'd0);
      chk({tag, "_resp_busy"}, 32'(busy),     32'd1);
      chk({tag, "_resp_done"}, 32'(done),     32'(acked));
      chk({tag, "_resp_err"},  32'(err),      32'(!acked));
      if (acked && !st) begin
        exp_ld_data = rd;
        exp_ld_lsb  = a[1:0];
      end
    end
    chk({tag, "_ld_data"}, ld_data,     exp_ld_data);
    chk({tag, "_ld_lsb"},  32'(ld_lsb), 32'(exp_ld_lsb));
    @(negedge clk);
    chk({tag, "_end_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_end_busy"},  32'(busy),      32'd0);
    chk({tag, "_end_done"},  32'(done),      32'd0);
    chk({tag, "_end_err"},   32'(err),       32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_addr   = 32'd0;
    req_size   = 2'd0;
    req_wdata  = 32'd0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);

    do_op("st_byte",  1'b1, 32'h0000_1003, 2'b00, 32'h0000_00AB, 1, 32'h0);
    do_op("st_half",  1'b1, 32'h0000_2002, 2'b01, 32'h0000_1234, 2, 32'h0);
    do_op("ld_word",  1'b0, 32'h0000_3000, 2'b10, 32'h0,         3, 32'hDEAD_BEEF);
    do_op("ld_tmo",   1'b0, 32'h0000_4000, 2'b10, 32'h0,         0, 32'h0);
    do_op("ld_mis",   1'b0, 32'h0000_1001, 2'b10, 32'h0,         1, 32'h1357_9BDF);
    do_op("st_sz11",  1'b1, 32'h0000_5001, 2'b11, 32'hCAFE_F00D, 4, 32'h0);

    // Ack while idle must be ignored.
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_ack   = 1'b0;
    chk("idle_ack_ready", 32'(req_ready), 32'd1);
    chk("idle_ack_done",  32'(done),      32'd0);
    chk("idle_ack_req",   32'(dmem_req),  32'd0);
    chk("idle_ack_ld",    ld_data,        exp_ld_data);

    // Reset two cycles into REQ abandons the request immediately.
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_addr  = 32'h0000_6004;
    req_size  = 2'b10;
    req_wdata = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_req_on", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_ld_data = 32'd0;
    exp_ld_lsb  = 2'd0;
    @(negedge clk);
    chk("rst_mid_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    do_op("after_rst", 1'b0, 32'h0000_7002, 2'b01, 32'h0, 2, 32'h0F0F_A5A5);

    for (int n = 0; n < 40; n++) begin
      do_op("rand", 1'($urandom), $urandom, 2'($urandom), $urandom,
            int'($urandom_range(1, 6)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
